// File: rtl/control_sequencer_if.sv
// Handshake and datapath-control bundle between the sequencer and its datapath.
interface control_sequencer_if;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          start;
    logic          mem_rdy;
    logic [DW-1:0] IR;
    logic [DW-1:0] enable;
    logic [DW-1:0] busSelect;
    logic [CW-1:0] Control_Signals;
    logic          MR_Read;
    logic          IncPC;
    logic          busy;
    logic          done;
    logic          illegal;

    // Datapath / requester side
    modport master (
        output start, mem_rdy, IR,
        input  enable, busSelect, Control_Signals, MR_Read, IncPC, busy, done, illegal
    );

    // Sequencer side
    modport slave (
        input  start, mem_rdy, IR,
        output enable, busSelect, Control_Signals, MR_Read, IncPC, busy, done, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer for a three-register ALU datapath.
// Outputs are decoded from the current state and IR so that T3..T5 strobes
// follow the instruction just latched into IR during T2.
module control_sequencer (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.slave  bus
);
    localparam int unsigned DW       = 32;
    localparam int unsigned CW       = 4;
    localparam int unsigned EN_PC    = 20;
    localparam int unsigned EN_MDR   = 21;
    localparam int unsigned EN_IR    = 23;
    localparam int unsigned EN_Z     = 24;
    localparam int unsigned EN_MAR   = 25;
    localparam int unsigned EN_Y     = 27;
    localparam int unsigned BS_ZLOW  = 19;
    localparam int unsigned BS_PC    = 20;
    localparam int unsigned BS_MDR   = 21;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT, S_ERR
    } state_t;

    state_t        state_q;
    logic [4:0]    opcode;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [3:0]    rc;
    logic [CW-1:0] alu_code;
    logic          op_alu;
    logic          op_halt;
    logic          unused_ir_bits;

    assign opcode         = bus.IR[31:27];
    assign ra             = bus.IR[26:23];
    assign rb             = bus.IR[22:19];
    assign rc             = bus.IR[18:15];
    assign unused_ir_bits = ^bus.IR[14:0];

    // Opcode decode to ALU operation code and instruction class
    always_comb begin
        alu_code = '0;
        op_alu   = 1'b0;
        op_halt  = 1'b0;
        case (opcode)
            5'b00011: begin alu_code = CW'(1); op_alu = 1'b1; end
            5'b00100: begin alu_code = CW'(2); op_alu = 1'b1; end
            5'b00101: begin alu_code = CW'(3); op_alu = 1'b1; end
            5'b00110: begin alu_code = CW'(4); op_alu = 1'b1; end
            5'b01001: begin alu_code = CW'(5); op_alu = 1'b1; end
            5'b01010: begin alu_code = CW'(6); op_alu = 1'b1; end
            5'b01011: begin alu_code = CW'(7); op_alu = 1'b1; end
            5'b01000: begin alu_code = CW'(8); op_alu = 1'b1; end
            5'b00111: begin alu_code = CW'(9); op_alu = 1'b1; end
            5'b11011: op_halt = 1'b1;
            default:  ;
        endcase
    end

    // State register with transitions; clr wins over every other input
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) state_q <= S_T0;
                S_T0:   state_q <= S_T1;
                S_T1:   if (bus.mem_rdy) state_q <= S_T2;
                S_T2:   state_q <= S_T3;
                S_T3: begin
                    if (op_alu)       state_q <= S_T4;
                    else if (op_halt) state_q <= S_HALT;
                    else              state_q <= S_ERR;
                end
                S_T4:   state_q <= S_T5;
                S_T5:   state_q <= bus.start ? S_T0 : S_IDLE;
                S_HALT: state_q <= S_HALT;
                S_ERR:  state_q <= S_ERR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-state strobe decode; busSelect is one-hot or zero by construction
    always_comb begin
        bus.enable          = '0;
        bus.busSelect       = '0;
        bus.Control_Signals = '0;
        bus.MR_Read         = 1'b0;
        bus.IncPC           = 1'b0;
        bus.busy            = 1'b0;
        bus.done            = 1'b0;
        bus.illegal         = 1'b0;
        case (state_q)
            S_T0: begin
                bus.busy             = 1'b1;
                bus.busSelect[BS_PC] = 1'b1;
                bus.enable[EN_MAR]   = 1'b1;
                bus.enable[EN_PC]    = 1'b1;
                bus.IncPC            = 1'b1;
            end
            S_T1: begin
                bus.busy            = 1'b1;
                bus.enable[EN_MDR]  = 1'b1;
                bus.MR_Read         = 1'b1;
            end
            S_T2: begin
                bus.busy              = 1'b1;
                bus.busSelect[BS_MDR] = 1'b1;
                bus.enable[EN_IR]     = 1'b1;
            end
            S_T3: begin
                bus.busy = 1'b1;
                if (op_alu) begin
                    bus.busSelect     = DW'(1) << rb;
                    bus.enable[EN_Y]  = 1'b1;
                end
            end
            S_T4: begin
                bus.busy            = 1'b1;
                bus.busSelect       = DW'(1) << rc;
                bus.enable[EN_Z]    = 1'b1;
                bus.Control_Signals = alu_code;
            end
            S_T5: begin
                bus.busy               = 1'b1;
                bus.busSelect[BS_ZLOW] = 1'b1;
                bus.enable             = DW'(1) << ra;
                bus.done               = 1'b1;
            end
            S_ERR:   bus.illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus pushes the expected output vector for each
// cycle; a negedge monitor pops and compares against the DUT.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] en;
        logic [31:0] bs;
        logic [3:0]  cs;
        logic        mr;
        logic        inc;
        logic        busy;
        logic        done;
        logic        ill;
        int          step;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    localparam logic [31:0] IR_ROR  = 32'h389A8000; // ROR R1,R3,R5
    localparam logic [31:0] IR_SUB  = 32'h27838000; // SUB R15,R0,R7
    localparam logic [31:0] IR_ADD  = 32'h19110000; // ADD R2,R2,R2
    localparam logic [31:0] IR_BAD  = 32'hF8000000; // opcode 11111
    localparam logic [31:0] IR_HALT = 32'hD8000000; // opcode 11011

    function automatic exp_t e_zero();
        exp_t e;
        e.en = '0; e.bs = '0; e.cs = '0; e.mr = 1'b0; e.inc = 1'b0;
        e.busy = 1'b0; e.done = 1'b0; e.ill = 1'b0; e.step = 0;
        return e;
    endfunction

    function automatic exp_t e_idle();
        return e_zero();
    endfunction

    function automatic exp_t e_t0();
        exp_t e = e_zero();
        e.busy = 1'b1; e.bs = 32'h0010_0000; e.en = 32'h0210_0000; e.inc = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_t1();
        exp_t e = e_zero();
        e.busy = 1'b1; e.en = 32'h0020_0000; e.mr = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_t2();
        exp_t e = e_zero();
        e.busy = 1'b1; e.bs = 32'h0020_0000; e.en = 32'h0080_0000;
        return e;
    endfunction

    function automatic exp_t e_t3(input logic [31:0] bs);
        exp_t e = e_zero();
        e.busy = 1'b1; e.bs = bs; e.en = 32'h0800_0000;
        return e;
    endfunction

    function automatic exp_t e_t3_trap();
        exp_t e = e_zero();
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_t4(input logic [31:0] bs, input logic [3:0] cs);
        exp_t e = e_zero();
        e.busy = 1'b1; e.bs = bs; e.en = 32'h0100_0000; e.cs = cs;
        return e;
    endfunction

    function automatic exp_t e_t5(input logic [31:0] en);
        exp_t e = e_zero();
        e.busy = 1'b1; e.bs = 32'h0008_0000; e.en = en; e.done = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_err();
        exp_t e = e_zero();
        e.ill = 1'b1;
        return e;
    endfunction

    // Apply current inputs at the next edge and expect e in the cycle after
    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        step_no++;
        e.step = step_no;
        sb.push_back(e);
    endtask

    // Monitor: compare the whole output vector once per scheduled cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.enable !== e.en || bus.busSelect !== e.bs ||
                bus.Control_Signals !== e.cs || bus.MR_Read !== e.mr ||
                bus.IncPC !== e.inc || bus.busy !== e.busy ||
                bus.done !== e.done || bus.illegal !== e.ill) begin
                errors++;
                $display("FAIL step%0d: got en=%h bs=%h cs=%0d mr=%b inc=%b busy=%b done=%b ill=%b, want en=%h bs=%h cs=%0d mr=%b inc=%b busy=%b done=%b ill=%b",
                         e.step, bus.enable, bus.busSelect, bus.Control_Signals, bus.MR_Read,
                         bus.IncPC, bus.busy, bus.done, bus.illegal,
                         e.en, e.bs, e.cs, e.mr, e.inc, e.busy, e.done, e.ill);
            end
            checks++;
            if ($countones(bus.busSelect) > 1) begin
                errors++;
                $display("FAIL onehot step%0d: busSelect=%h has more than one bit set", e.step, bus.busSelect);
            end
        end
    end

    initial begin
        clr = 1'b0; bus.start = 1'b0; bus.mem_rdy = 1'b0; bus.IR = '0;

        // Reset state
        tick(e_idle());
        tick(e_idle());

        // ROR R1,R3,R5 with memory ready immediately: 6-cycle instruction
        clr = 1'b1; bus.IR = IR_ROR; bus.mem_rdy = 1'b1; bus.start = 1'b1;
        tick(e_t0());
        bus.start = 1'b0;
        tick(e_t1());
        tick(e_t2());
        tick(e_t3(32'h0000_0008));
        tick(e_t4(32'h0000_0020, 4'd9));
        tick(e_t5(32'h0000_0002));
        tick(e_idle());

        // SUB R15,R0,R7 with three wait cycles in T1: 9-cycle instruction
        bus.IR = IR_SUB; bus.start = 1'b1;
        tick(e_t0());
        bus.start = 1'b0; bus.mem_rdy = 1'b0;
        tick(e_t1());
        tick(e_t1());
        tick(e_t1());
        tick(e_t1());
        bus.mem_rdy = 1'b1;
        tick(e_t2());
        tick(e_t3(32'h0000_0001));
        tick(e_t4(32'h0000_0080, 4'd2));
        tick(e_t5(32'h0000_8000));
        tick(e_idle());

        // ADD R2,R2,R2 with start held: three back-to-back instructions
        bus.IR = IR_ADD; bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(e_t0());
            tick(e_t1());
            tick(e_t2());
            tick(e_t3(32'h0000_0004));
            tick(e_t4(32'h0000_0004, 4'd1));
            if (i == 2) bus.start = 1'b0;
            tick(e_t5(32'h0000_0004));
        end
        tick(e_idle());

        // clr during T4 overrides start and mem_rdy; start needed afterwards
        bus.IR = IR_SUB; bus.start = 1'b1;
        tick(e_t0());
        bus.start = 1'b0;
        tick(e_t1());
        tick(e_t2());
        tick(e_t3(32'h0000_0001));
        tick(e_t4(32'h0000_0080, 4'd2));
        clr = 1'b0; bus.start = 1'b1;
        tick(e_idle());
        clr = 1'b1; bus.start = 1'b0;
        tick(e_idle());
        tick(e_idle());

        // clr during a T1 memory wait
        bus.start = 1'b1;
        tick(e_t0());
        bus.start = 1'b0; bus.mem_rdy = 1'b0;
        tick(e_t1());
        tick(e_t1());
        clr = 1'b0; bus.mem_rdy = 1'b1; bus.start = 1'b1;
        tick(e_idle());
        clr = 1'b1; bus.start = 1'b0;
        tick(e_idle());

        // Illegal opcode traps into ERR; start ignored until clr
        bus.IR = IR_BAD; bus.start = 1'b1;
        tick(e_t0());
        bus.start = 1'b0;
        tick(e_t1());
        tick(e_t2());
        tick(e_t3_trap());
        tick(e_err());
        bus.start = 1'b1;
        tick(e_err());
        tick(e_err());
        clr = 1'b0;
        tick(e_idle());
        clr = 1'b1; bus.start = 1'b0;
        tick(e_idle());

        // HALT opcode parks in HALT with no done pulse; clr returns to IDLE
        bus.IR = IR_HALT; bus.start = 1'b1;
        tick(e_t0());
        bus.start = 1'b0;
        tick(e_t1());
        tick(e_t2());
        tick(e_t3_trap());
        tick(e_idle());
        bus.start = 1'b1;
        tick(e_idle());
        tick(e_idle());
        clr = 1'b0;
        tick(e_idle());
        clr = 1'b1; bus.start = 1'b0;
        tick(e_idle());

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles never compared, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
